// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Kept as plain logic constants so older netlists that probe the raw state bit still line up.
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t S_REQ  = 1'b0;
  localparam fetch_state_t S_WAIT = 1'b1;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs a single-outstanding req/gnt/rvalid fetch and
// holds one fetched instruction for the IF/ID register downstream.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            ifid_write_en,
  output logic            ifid_flush
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic            kill;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;

  logic            consume;
  logic            has_room;
  logic            granted;
  logic            resp;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_low;

  assign consume         = buf_valid && !stall && !redirect_valid;
  assign has_room        = !buf_valid || consume;
  assign granted         = imem_req && imem_gnt;
  assign resp            = (state == S_WAIT) && imem_rvalid;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Request is gated by rst so the port is quiet for the whole reset pulse.
  assign imem_req  = !rst && (state == S_REQ) && has_room;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      case (state)
        S_REQ:   if (granted) state <= S_WAIT;
        S_WAIT:  if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  // A redirect always wins over the sequential increment, even on a grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (granted) req_addr <= pc;
      if (redirect_valid) pc <= redirect_target;
      else if (granted) pc <= pc + XLEN'(4);
    end
  end

  // kill marks the outstanding response as belonging to a squashed path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill <= 1'b0;
    end else if (resp) begin
      kill <= 1'b0;
    end else if (redirect_valid && ((state == S_WAIT) || granted)) begin
      kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= INSTR_NOP;
    end else if (redirect_valid) begin
      buf_valid <= 1'b0;
    end else if (resp && !kill) begin
      buf_valid <= 1'b1;
      buf_pc    <= req_addr;
      buf_instr <= imem_rdata;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  assign if_pc    = buf_pc;
  assign if_instr = buf_valid ? buf_instr : INSTR_NOP;

  // Redirect beats stall; an empty buffer while running becomes a bubble.
  always_comb begin
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    if (redirect_valid) begin
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b1;
    end else if (stall) begin
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b0;
    end else if (!buf_valid) begin
      ifid_flush    = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scripted vector table, reset corner case,
// then randomized traffic against a simple expected-PC-stream model.
module tb_fetch_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ifid_write_en;
  logic        ifid_flush;

  int total_checks  = 0;
  int passed_checks = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr),
    .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc,
                                input logic g, input logic v, input logic [31:0] d);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = d;
  endtask

  task automatic add_vec(input logic s, input logic r, input logic [31:0] rpc,
                         input logic g, input logic v, input logic [31:0] d,
                         input logic ereq, input logic [31:0] eaddr,
                         input logic ewe, input logic efl,
                         input logic [31:0] epc, input logic [31:0] einstr);
    vec_t t;
    t.stall = s;  t.redir = r;  t.rpc = rpc;  t.gnt = g;  t.rvalid = v;  t.rdata = d;
    t.exp_req = ereq;  t.exp_addr = eaddr;  t.exp_we = ewe;  t.exp_flush = efl;
    t.exp_pc = epc;  t.exp_instr = einstr;
    vecs.push_back(t);
  endtask

  localparam logic [31:0] NOP = INSTR_NOP;

  initial begin
    logic        pending;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic [31:0] exp_pc;
    int          delivered;
    int          hold;
    logic        prev_req_wait;
    logic [31:0] prev_addr;
    logic        prev_redir;
    logic        s, r, g, v;
    logic [31:0] rpc, d;

    // Scripted table: start-up, stall hold, redirect/kill corners, PC wrap.
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h0010_0093,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h4,1,0,32'h0,32'h0010_0093);
    add_vec(0,0,32'h0,0,1,32'h0020_0113,   0,32'h0,1,1,32'h0,NOP);
    for (int i = 0; i < 4; i++)
      add_vec(1,0,32'h0,1,0,32'h0,         0,32'h0,0,0,32'h4,32'h0020_0113);
    add_vec(0,0,32'h0,0,0,32'h0,           1,32'h8,1,0,32'h4,32'h0020_0113);
    add_vec(0,0,32'h0,0,0,32'h0,           1,32'h8,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h8,1,1,32'h0,NOP);
    add_vec(0,1,32'h100,0,0,32'h0,         0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h0030_0193,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h100,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h1111_1111,   0,32'h0,1,1,32'h0,NOP);
    add_vec(1,1,32'h200,0,0,32'h0,         0,32'h0,1,1,32'h100,32'h1111_1111);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h200,1,1,32'h0,NOP);
    add_vec(0,1,32'h103,0,1,32'h2222_2222, 0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h100,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h3333_3333,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,0,32'h0,           1,32'h104,1,0,32'h100,32'h3333_3333);
    add_vec(0,1,32'h40,1,0,32'h0,          1,32'h104,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h4444_4444,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h40,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h5555_5555,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,0,32'h0,           1,32'h44,1,0,32'h40,32'h5555_5555);
    add_vec(0,1,32'hFFFF_FFFC,0,0,32'h0,   1,32'h44,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'hFFFF_FFFC,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,1,32'h6666_6666,   0,32'h0,1,1,32'h0,NOP);
    add_vec(0,0,32'h0,0,0,32'h0,           1,32'h0,1,0,32'hFFFF_FFFC,32'h6666_6666);
    add_vec(0,0,32'h0,1,0,32'h0,           1,32'h0,1,1,32'h0,NOP);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_req", imem_req, 0);
    check_output("reset_instr", if_instr, NOP);
    check_output("reset_flush", ifid_flush, 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                     vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      #1;
      check_output($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check_output($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d_we", i), ifid_write_en, vecs[i].exp_we);
      check_output($sformatf("v%0d_flush", i), ifid_flush, vecs[i].exp_flush);
      check_output($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
      if (vecs[i].exp_instr != NOP)
        check_output($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
      @(posedge clk);
      #1;
    end

    // Reset dropped on the fetch while a response is still outstanding.
    apply_stimulus(0,0,32'h0,0,0,32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_output("midwait_rst_req", imem_req, 0);
    check_output("midwait_rst_instr", if_instr, NOP);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(0,0,32'h0,1,0,32'h0);
    #1;
    check_output("restart_req", imem_req, 1);
    check_output("restart_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    apply_stimulus(0,0,32'h0,0,1,32'h7777_7777);
    #1;
    check_output("restart_wait_req", imem_req, 0);
    @(posedge clk);
    #1;
    apply_stimulus(0,0,32'h0,0,0,32'h0);
    #1;
    check_output("restart_flush", ifid_flush, 0);
    check_output("restart_pc", if_pc, 32'h0);
    check_output("restart_instr", if_instr, 32'h7777_7777);

    // Randomized traffic against the expected in-order PC stream.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pending = 0; pend_addr = '0; pend_cnt = 0;
    exp_pc = 32'h0; delivered = 0; hold = 0;
    prev_req_wait = 0; prev_addr = '0; prev_redir = 0;

    for (int cyc = 0; cyc < 20000 && delivered < 1000; cyc++) begin
      s   = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 32) == 0);
      rpc = $urandom & 32'h0000_0FFF;
      if (hold == 0 && $urandom_range(0, 49) == 0) hold = 5;
      g = (hold == 0) && ($urandom_range(0, 2) != 0);
      if (hold > 0) hold--;
      v = 0;
      d = '0;
      if (pending) begin
        if (pend_cnt == 0) begin
          v = 1;
          d = mem_word(pend_addr);
        end else begin
          pend_cnt--;
        end
      end
      apply_stimulus(s, r, rpc, g, v, d);
      #1;
      if (imem_rvalid) assert (pending);
      if (pending) check_output("single_outstanding", imem_req, 0);
      if (prev_req_wait && !prev_redir) begin
        check_output("req_held", imem_req, 1);
        check_output("addr_held", imem_addr, prev_addr);
      end
      check_output("write_en", ifid_write_en, r || !s);
      if (r) check_output("flush_on_redirect", ifid_flush, 1);
      if (ifid_write_en && !ifid_flush) begin
        check_output("stream_pc", if_pc, exp_pc);
        check_output("stream_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (r) exp_pc = {rpc[31:2], 2'b00};
      if (v) pending = 0;
      if (imem_req && g) begin
        pending   = 1;
        pend_addr = imem_addr;
        pend_cnt  = $urandom_range(0, 3);
      end
      prev_req_wait = imem_req && !g;
      prev_addr     = imem_addr;
      prev_redir    = r;
      @(posedge clk);
      #1;
    end
    check_output("delivered_1000", (delivered >= 1000) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
